// File: rtl/conf_word_dispatcher_if.sv
// Reader-side word stream and PE-side configuration port of the dispatcher.
// master = dispatcher, slave = its environment (reader + PE).
interface conf_word_dispatcher_if #(
    parameter int unsigned ADDR_W = 12
);
    logic [31:0]       din;
    logic              din_valid;
    logic              rnready;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [31:0]       cfg_data;
    logic [ADDR_W-1:0] cfg_addr;
    logic [15:0]       cfg_idx;

    modport master (
        input  din,
        input  din_valid,
        input  cfg_ready,
        output rnready,
        output cfg_valid,
        output cfg_data,
        output cfg_addr,
        output cfg_idx
    );

    modport slave (
        output din,
        output din_valid,
        output cfg_ready,
        input  rnready,
        input  cfg_valid,
        input  cfg_data,
        input  cfg_addr,
        input  cfg_idx
    );
endinterface

// File: rtl/conf_word_dispatcher.sv
// Buffers configuration words, parses block headers and dispatches payload
// words to the addressed PE configuration port.
module conf_word_dispatcher #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   conf_en,
    output logic                   config_done,
    output logic                   cfg_err,
    conf_word_dispatcher_if.master bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [3:0]  OP_CFG = 4'h1;
    localparam logic [3:0]  OP_END = 4'hF;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PAY  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0]  op;
        logic [11:0] hi;
        logic [15:0] cnt;
    } hdr_t;

    state_e            state_q, state_d;
    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       remain_q, remain_d;
    logic [15:0]       idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rnready_q, rnready_d;

    logic              empty, full;
    logic              push_req, push, pop, overflow;
    logic              cfg_valid_c;
    logic [31:0]       head;
    hdr_t              hdr;
    logic [ADDR_W-1:0] hdr_tgt;
    logic              hdr_is_blk, hdr_is_end;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign head       = mem_q[rd_ptr_q];
    assign hdr        = hdr_t'(head);
    assign hdr_tgt    = head[16 +: ADDR_W];
    assign hdr_is_blk = (hdr.op == OP_CFG) && (hdr.cnt != 16'd0);
    assign hdr_is_end = (hdr.op == OP_END);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!conf_en) begin
            state_d = S_HDR;
        end else begin
            case (state_q)
                S_HDR: begin
                    if (!empty) begin
                        if (hdr_is_blk) begin
                            state_d = S_PAY;
                        end else if (hdr_is_end) begin
                            state_d = S_DONE;
                        end else if (hdr.op != OP_CFG) begin
                            state_d = S_ERR;
                        end
                    end
                end
                S_PAY: begin
                    if (overflow) begin
                        state_d = S_ERR;
                    end else if (pop && (remain_q == 16'd1)) begin
                        state_d = S_HDR;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Output / FIFO control logic; DONE and ERR neither push nor pop
    always_comb begin
        cfg_valid_c = 1'b0;
        push_req    = 1'b0;
        pop         = 1'b0;
        case (state_q)
            S_HDR: begin
                push_req = bus.din_valid & conf_en;
                pop      = !empty;
            end
            S_PAY: begin
                cfg_valid_c = !empty;
                push_req    = bus.din_valid & conf_en;
                pop         = cfg_valid_c & bus.cfg_ready;
            end
            default: begin
                cfg_valid_c = 1'b0;
            end
        endcase
        // A simultaneous pop frees the slot, so a full FIFO still accepts
        push     = push_req & (!full | pop);
        overflow = push_req & full & !pop;
    end

    // Block bookkeeping and sticky flags
    always_comb begin
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        remain_d = remain_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        done_d   = done_q;
        err_d    = err_q;
        if (!conf_en) begin
            count_d = '0;
            idx_d   = 16'd0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_HDR: begin
                    if (!empty) begin
                        if (hdr_is_blk) begin
                            addr_d   = hdr_tgt;
                            remain_d = hdr.cnt;
                            idx_d    = 16'd0;
                        end else if (hdr_is_end) begin
                            done_d = 1'b1;
                        end else if (hdr.op != OP_CFG) begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_PAY: begin
                    if (pop) begin
                        idx_d    = idx_q + 16'd1;
                        remain_d = remain_q - 16'd1;
                    end
                    if (overflow) begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    err_d = err_q;
                end
            endcase
        end
        // Two-entry margin covers the reader's one-cycle reaction lag
        rnready_d = conf_en &
                    ((count_d >= CNT_W'(FIFO_DEPTH - 2)) | done_d | err_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            remain_q  <= 16'd0;
            idx_q     <= 16'd0;
            addr_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rnready_q <= 1'b0;
        end else begin
            if (!conf_en) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
            end
            count_q   <= count_d;
            remain_q  <= remain_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rnready_q <= rnready_d;
        end
    end

    // Storage needs no reset: contents are only read while count_q is non-zero
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end

    assign bus.rnready   = rnready_q;
    assign bus.cfg_valid = cfg_valid_c;
    assign bus.cfg_data  = empty ? 32'd0 : head;
    assign bus.cfg_addr  = addr_q;
    assign bus.cfg_idx   = idx_q;
    assign config_done   = done_q;
    assign cfg_err       = err_q;
endmodule
